// File: rtl/shot_pkg.sv
// shot_pkg: shared states, player ids and damage values for the shot turn scheduler.
package shot_pkg;
    typedef enum logic [2:0] {S_EMPTY, S_AIM, S_ARMED, S_FIRE, S_OVER} state_t;
    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;
    localparam int DMG_NORMAL = 1;
    localparam int DMG_SAW = 2;
endpackage

// File: rtl/shot_turn_ctrl_shell_mag.sv
// shell_mag: shell magazine shift register with remaining-shell count; bit 0 is the next shell.
module shell_mag #(
    parameter int MAG_DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clear,
    input  logic                 i_load,
    input  logic                 i_pop,
    input  logic [MAG_DEPTH-1:0] i_shells,
    input  logic [CNT_W-1:0]     i_count,
    output logic                 o_head,
    output logic                 o_empty,
    output logic [CNT_W-1:0]     o_count
);
    logic [MAG_DEPTH-1:0] mag;
    logic [CNT_W-1:0] cnt, cnt_clamped;
    assign cnt_clamped = (i_count == '0) ? CNT_W'(1)
                       : (i_count > CNT_W'(MAG_DEPTH)) ? CNT_W'(MAG_DEPTH) : i_count;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mag <= '0;
            cnt <= '0;
        end else if (i_clear) begin
            mag <= '0;
            cnt <= '0;
        end else if (i_load) begin
            mag <= i_shells;
            cnt <= cnt_clamped;
        end else if (i_pop && cnt != '0) begin
            mag <= mag >> 1;
            cnt <= cnt - CNT_W'(1);
        end
    end
    assign o_head = mag[0];
    assign o_empty = (cnt == '0);
    assign o_count = cnt;
endmodule

// File: rtl/shot_turn_ctrl.sv
// shot_turn_ctrl: two-player turn scheduler resolving shots from a loaded magazine.
// Optional DOUBLE_DAMAGE_EN adds i_saw / o_saw_armed for a one-shot double-damage flag.
module shot_turn_ctrl
    import shot_pkg::*;
#(
    parameter int MAG_DEPTH = 8,
    parameter int HP_MAX = 4,
    parameter int HP_W = 3,
    parameter int CNT_W = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_new_game,
    input  logic                 i_load,
    input  logic [MAG_DEPTH-1:0] i_load_shells,
    input  logic [CNT_W-1:0]     i_load_count,
    output logic                 o_load_ready,
    input  logic                 i_to_p0,
    input  logic                 i_to_p1,
    input  logic                 i_trigger,
`ifdef DOUBLE_DAMAGE_EN
    input  logic                 i_saw,
    output logic                 o_saw_armed,
`endif
    output logic                 o_turn,
    output logic                 o_target_valid,
    output logic                 o_target,
    output logic [CNT_W-1:0]     o_shell_count,
    output logic [HP_W-1:0]      o_hp0,
    output logic [HP_W-1:0]      o_hp1,
    output logic                 o_fire_valid,
    output logic                 o_fire_live,
    output logic                 o_fire_target,
    output logic                 o_game_over,
    output logic                 o_winner
);
    state_t state, state_n;
    logic turn, turn_n, target, target_n, winner, winner_n, saw, saw_n;
    logic fire_valid, fire_valid_n, fire_live, fire_live_n, fire_target, fire_target_n;
    logic [HP_W-1:0] hp0, hp0_n, hp1, hp1_n, hit_hp, hit_hp_n, dmg;
    logic mag_load, mag_pop, mag_clear, mag_head, mag_empty;
    logic [CNT_W-1:0] mag_count;

    shell_mag #(.MAG_DEPTH(MAG_DEPTH), .CNT_W(CNT_W)) u_mag (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(mag_clear), .i_load(mag_load),
        .i_pop(mag_pop), .i_shells(i_load_shells), .i_count(i_load_count),
        .o_head(mag_head), .o_empty(mag_empty), .o_count(mag_count)
    );

    assign dmg = saw ? HP_W'(DMG_SAW) : HP_W'(DMG_NORMAL);
    assign hit_hp = target ? hp1 : hp0;
    assign hit_hp_n = (hit_hp > dmg) ? hit_hp - dmg : '0;

    always_comb begin
        state_n = state;
        turn_n = turn;
        target_n = target;
        winner_n = winner;
        hp0_n = hp0;
        hp1_n = hp1;
        fire_valid_n = 1'b0;
        fire_live_n = 1'b0;
        fire_target_n = 1'b0;
        mag_load = 1'b0;
        mag_pop = 1'b0;
        mag_clear = 1'b0;
`ifdef DOUBLE_DAMAGE_EN
        saw_n = saw | (i_saw && (state == S_AIM || state == S_ARMED));
`else
        saw_n = 1'b0;
`endif
        case (state)
            S_EMPTY: if (i_load) begin
                mag_load = 1'b1;
                state_n = S_AIM;
            end
            S_AIM: if (i_to_p0 || i_to_p1) begin
                target_n = i_to_p0 ? P0 : P1;
                state_n = S_ARMED;
            end
            S_ARMED: begin
                if (i_trigger && !mag_empty) state_n = S_FIRE;
                else if (i_to_p0 || i_to_p1) target_n = i_to_p0 ? P0 : P1;
            end
            S_FIRE: begin
                mag_pop = 1'b1;
                fire_valid_n = 1'b1;
                fire_live_n = mag_head;
                fire_target_n = target;
                saw_n = 1'b0;
                if (mag_head && target) hp1_n = hit_hp_n;
                if (mag_head && !target) hp0_n = hit_hp_n;
                // only a blank aimed at oneself keeps the turn
                turn_n = (!mag_head && target == turn) ? turn : ~turn;
                if (mag_head && hit_hp_n == '0) begin
                    state_n = S_OVER;
                    winner_n = ~target;
                end else begin
                    state_n = (mag_count == CNT_W'(1)) ? S_EMPTY : S_AIM;
                end
            end
            S_OVER: ;
            default: state_n = S_EMPTY;
        endcase
        if (i_new_game) begin
            state_n = S_EMPTY;
            turn_n = P0;
            hp0_n = HP_W'(HP_MAX);
            hp1_n = HP_W'(HP_MAX);
            mag_clear = 1'b1;
            mag_load = 1'b0;
            mag_pop = 1'b0;
            fire_valid_n = 1'b0;
            fire_live_n = 1'b0;
            fire_target_n = 1'b0;
            saw_n = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_EMPTY;
            turn <= P0;
            target <= P0;
            winner <= P0;
            hp0 <= HP_W'(HP_MAX);
            hp1 <= HP_W'(HP_MAX);
            fire_valid <= 1'b0;
            fire_live <= 1'b0;
            fire_target <= 1'b0;
            saw <= 1'b0;
        end else begin
            state <= state_n;
            turn <= turn_n;
            target <= target_n;
            winner <= winner_n;
            hp0 <= hp0_n;
            hp1 <= hp1_n;
            fire_valid <= fire_valid_n;
            fire_live <= fire_live_n;
            fire_target <= fire_target_n;
            saw <= saw_n;
        end
    end

    assign o_load_ready = (state == S_EMPTY);
    assign o_target_valid = (state == S_ARMED);
    assign o_game_over = (state == S_OVER);
    assign o_turn = turn;
    assign o_target = target;
    assign o_winner = winner;
    assign o_shell_count = mag_count;
    assign o_hp0 = hp0;
    assign o_hp1 = hp1;
    assign o_fire_valid = fire_valid;
    assign o_fire_live = fire_live;
    assign o_fire_target = fire_target;
`ifdef DOUBLE_DAMAGE_EN
    assign o_saw_armed = saw;
`endif
endmodule

// File: tb/tb_shot_turn_ctrl.sv
// tb_shot_turn_ctrl: directed self-checking bench for shot_turn_ctrl (default and DOUBLE_DAMAGE_EN builds).
module tb_shot_turn_ctrl;
    logic clk = 1'b0, rst_n = 1'b0;
    logic i_new_game = 0, i_load = 0, i_to_p0 = 0, i_to_p1 = 0, i_trigger = 0;
    logic [7:0] i_load_shells = '0;
    logic [3:0] i_load_count = '0;
    logic o_load_ready, o_turn, o_target_valid, o_target, o_fire_valid, o_fire_live;
    logic o_fire_target, o_game_over, o_winner;
    logic [3:0] o_shell_count;
    logic [2:0] o_hp0, o_hp1;
    int total = 0, bad = 0;
`ifdef DOUBLE_DAMAGE_EN
    logic i_saw = 0, o_saw_armed;
`endif

    shot_turn_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_new_game(i_new_game), .i_load(i_load),
        .i_load_shells(i_load_shells), .i_load_count(i_load_count), .o_load_ready(o_load_ready),
        .i_to_p0(i_to_p0), .i_to_p1(i_to_p1), .i_trigger(i_trigger),
`ifdef DOUBLE_DAMAGE_EN
        .i_saw(i_saw), .o_saw_armed(o_saw_armed),
`endif
        .o_turn(o_turn), .o_target_valid(o_target_valid), .o_target(o_target),
        .o_shell_count(o_shell_count), .o_hp0(o_hp0), .o_hp1(o_hp1),
        .o_fire_valid(o_fire_valid), .o_fire_live(o_fire_live), .o_fire_target(o_fire_target),
        .o_game_over(o_game_over), .o_winner(o_winner)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic load(input logic [7:0] sh, input logic [3:0] c);
        i_load_shells = sh; i_load_count = c; i_load = 1; step(); i_load = 0;
    endtask

    task automatic aim(input logic t);
        if (t) i_to_p1 = 1; else i_to_p0 = 1;
        step(); i_to_p0 = 0; i_to_p1 = 0;
    endtask

    // ends on the cycle where the fire pulse is visible
    task automatic fire();
        i_trigger = 1; step(); i_trigger = 0; step();
    endtask

    task automatic new_game();
        i_new_game = 1; step(); i_new_game = 0;
    endtask

    task automatic test_reset();
        step(); step();
        total++; if (o_load_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0d exp=1", o_load_ready); end
        total++; if (o_hp0 !== 3'd4 || o_hp1 !== 3'd4) begin bad++; $display("FAIL rst_hp got=%0d/%0d exp=4/4", o_hp0, o_hp1); end
        total++; if (o_turn !== 1'b0 || o_shell_count !== 4'd0) begin bad++; $display("FAIL rst_turn_cnt got=%0d/%0d exp=0/0", o_turn, o_shell_count); end
        total++; if (o_fire_valid !== 1'b0 || o_game_over !== 1'b0 || o_target_valid !== 1'b0) begin bad++; $display("FAIL rst_flags got=%0d%0d%0d exp=000", o_fire_valid, o_game_over, o_target_valid); end
        rst_n = 1;
    endtask

    task automatic test_live_shot();
        load(8'b0000_0101, 4'd3);
        total++; if (o_shell_count !== 4'd3 || o_load_ready !== 1'b0) begin bad++; $display("FAIL load_cnt got=%0d/%0d exp=3/0", o_shell_count, o_load_ready); end
        aim(1'b1);
        total++; if (o_target_valid !== 1'b1 || o_target !== 1'b1) begin bad++; $display("FAIL aim_p1 got=%0d/%0d exp=1/1", o_target_valid, o_target); end
        fire();
        total++; if (o_fire_valid !== 1'b1 || o_fire_live !== 1'b1 || o_fire_target !== 1'b1) begin bad++; $display("FAIL live_pulse got=%0d%0d%0d exp=111", o_fire_valid, o_fire_live, o_fire_target); end
        total++; if (o_hp1 !== 3'd3 || o_turn !== 1'b1 || o_shell_count !== 4'd2) begin bad++; $display("FAIL live_state got hp1=%0d turn=%0d cnt=%0d exp 3/1/2", o_hp1, o_turn, o_shell_count); end
        step();
        total++; if (o_fire_valid !== 1'b0) begin bad++; $display("FAIL pulse_width got=%0d exp=0", o_fire_valid); end
    endtask

    task automatic test_blank_self();
        aim(1'b1); fire();
        total++; if (o_fire_valid !== 1'b1 || o_fire_live !== 1'b0) begin bad++; $display("FAIL blank_pulse got=%0d%0d exp=10", o_fire_valid, o_fire_live); end
        total++; if (o_turn !== 1'b1 || o_hp0 !== 3'd4 || o_hp1 !== 3'd3 || o_shell_count !== 4'd1) begin bad++; $display("FAIL blank_state got turn=%0d hp=%0d/%0d cnt=%0d exp 1 4/3 1", o_turn, o_hp0, o_hp1, o_shell_count); end
    endtask

    task automatic test_last_shell();
        aim(1'b0); fire();
        total++; if (o_hp0 !== 3'd3 || o_turn !== 1'b0 || o_shell_count !== 4'd0) begin bad++; $display("FAIL last_state got hp0=%0d turn=%0d cnt=%0d exp 3/0/0", o_hp0, o_turn, o_shell_count); end
        total++; if (o_load_ready !== 1'b1) begin bad++; $display("FAIL last_ready got=%0d exp=1", o_load_ready); end
        i_trigger = 1; step(); i_trigger = 0;
        total++; if (o_fire_valid !== 1'b0) begin bad++; $display("FAIL empty_trig1 got=%0d exp=0", o_fire_valid); end
        step();
        total++; if (o_fire_valid !== 1'b0 || o_load_ready !== 1'b1) begin bad++; $display("FAIL empty_trig2 got=%0d/%0d exp=0/1", o_fire_valid, o_load_ready); end
    endtask

    task automatic test_game_over();
        new_game();
        total++; if (o_hp0 !== 3'd4 || o_hp1 !== 3'd4 || o_turn !== 1'b0) begin bad++; $display("FAIL ng_restore got=%0d/%0d/%0d exp=4/4/0", o_hp0, o_hp1, o_turn); end
        load(8'hFF, 4'd8);
        for (int i = 0; i < 4; i++) begin aim(1'b1); fire(); end
        total++; if (o_hp1 !== 3'd0 || o_game_over !== 1'b1 || o_winner !== 1'b0) begin bad++; $display("FAIL over got hp1=%0d over=%0d win=%0d exp 0/1/0", o_hp1, o_game_over, o_winner); end
        total++; if (o_shell_count !== 4'd4 || o_hp0 !== 3'd4) begin bad++; $display("FAIL over_cnt got=%0d/%0d exp=4/4", o_shell_count, o_hp0); end
        i_trigger = 1; i_load = 1; i_to_p0 = 1; step(); step();
        i_trigger = 0; i_load = 0; i_to_p0 = 0;
        total++; if (o_game_over !== 1'b1 || o_fire_valid !== 1'b0 || o_shell_count !== 4'd4) begin bad++; $display("FAIL over_hold got=%0d/%0d/%0d exp=1/0/4", o_game_over, o_fire_valid, o_shell_count); end
        new_game();
        total++; if (o_hp0 !== 3'd4 || o_hp1 !== 3'd4 || o_turn !== 1'b0 || o_game_over !== 1'b0 || o_load_ready !== 1'b1 || o_shell_count !== 4'd0) begin bad++; $display("FAIL over_ng got hp=%0d/%0d turn=%0d over=%0d rdy=%0d cnt=%0d", o_hp0, o_hp1, o_turn, o_game_over, o_load_ready, o_shell_count); end
    endtask

    task automatic test_priority();
        load(8'b0000_0010, 4'd2);
        aim(1'b0);
        i_to_p1 = 1; i_trigger = 1; step(); i_to_p1 = 0; i_trigger = 0; step();
        total++; if (o_fire_valid !== 1'b1 || o_fire_target !== 1'b0 || o_fire_live !== 1'b0) begin bad++; $display("FAIL trig_prio got=%0d%0d%0d exp=100", o_fire_valid, o_fire_target, o_fire_live); end
        total++; if (o_turn !== 1'b0 || o_shell_count !== 4'd1) begin bad++; $display("FAIL trig_prio_state got=%0d/%0d exp=0/1", o_turn, o_shell_count); end
        i_to_p0 = 1; i_to_p1 = 1; step(); i_to_p0 = 0; i_to_p1 = 0;
        total++; if (o_target_valid !== 1'b1 || o_target !== 1'b0) begin bad++; $display("FAIL aim_prio got=%0d/%0d exp=1/0", o_target_valid, o_target); end
        fire();
        total++; if (o_hp0 !== 3'd3 || o_turn !== 1'b1 || o_load_ready !== 1'b1) begin bad++; $display("FAIL self_live got=%0d/%0d/%0d exp=3/1/1", o_hp0, o_turn, o_load_ready); end
    endtask

    task automatic test_clamp();
        new_game();
        load(8'h01, 4'd0);
        total++; if (o_shell_count !== 4'd1) begin bad++; $display("FAIL clamp_lo got=%0d exp=1", o_shell_count); end
        aim(1'b1); fire();
        total++; if (o_hp1 !== 3'd3 || o_shell_count !== 4'd0 || o_load_ready !== 1'b1) begin bad++; $display("FAIL clamp_lo_fire got=%0d/%0d/%0d exp=3/0/1", o_hp1, o_shell_count, o_load_ready); end
        load(8'hFF, 4'd15);
        total++; if (o_shell_count !== 4'd8) begin bad++; $display("FAIL clamp_hi got=%0d exp=8", o_shell_count); end
        new_game();
        total++; if (o_shell_count !== 4'd0 || o_hp1 !== 3'd4) begin bad++; $display("FAIL clamp_ng got=%0d/%0d exp=0/4", o_shell_count, o_hp1); end
    endtask

    task automatic test_new_game_prio();
        i_load_shells = 8'hFF; i_load_count = 4'd4; i_load = 1; i_new_game = 1; step(); i_load = 0; i_new_game = 0;
        total++; if (o_shell_count !== 4'd0 || o_load_ready !== 1'b1) begin bad++; $display("FAIL ng_load got=%0d/%0d exp=0/1", o_shell_count, o_load_ready); end
        load(8'h01, 4'd1); aim(1'b1);
        i_trigger = 1; step(); i_trigger = 0; i_new_game = 1; step(); i_new_game = 0;
        total++; if (o_fire_valid !== 1'b0 || o_hp1 !== 3'd4 || o_shell_count !== 4'd0 || o_load_ready !== 1'b1) begin bad++; $display("FAIL ng_abort got fv=%0d hp1=%0d cnt=%0d rdy=%0d", o_fire_valid, o_hp1, o_shell_count, o_load_ready); end
    endtask

    task automatic test_async_reset();
        load(8'h01, 4'd1); aim(1'b1);
        i_trigger = 1; step(); i_trigger = 0;
        #2 rst_n = 0; #1;
        total++; if (o_load_ready !== 1'b1 || o_shell_count !== 4'd0) begin bad++; $display("FAIL arst_now got=%0d/%0d exp=1/0", o_load_ready, o_shell_count); end
        step();
        total++; if (o_fire_valid !== 1'b0 || o_hp1 !== 3'd4) begin bad++; $display("FAIL arst_abort got=%0d/%0d exp=0/4", o_fire_valid, o_hp1); end
        rst_n = 1; step();
    endtask

`ifdef DOUBLE_DAMAGE_EN
    task automatic test_saw();
        new_game();
        load(8'b0000_0111, 4'd3);
        i_saw = 1; step(); i_saw = 0;
        total++; if (o_saw_armed !== 1'b1) begin bad++; $display("FAIL saw_set got=%0d exp=1", o_saw_armed); end
        aim(1'b0); fire();
        total++; if (o_hp0 !== 3'd2 || o_saw_armed !== 1'b0 || o_turn !== 1'b1) begin bad++; $display("FAIL saw_live got=%0d/%0d/%0d exp=2/0/1", o_hp0, o_saw_armed, o_turn); end
        aim(1'b0); fire();
        total++; if (o_hp0 !== 3'd1) begin bad++; $display("FAIL saw_normal got=%0d exp=1", o_hp0); end
        i_saw = 1; step(); i_saw = 0;
        aim(1'b0); fire();
        total++; if (o_hp0 !== 3'd0 || o_saw_armed !== 1'b0 || o_game_over !== 1'b1 || o_winner !== 1'b1) begin bad++; $display("FAIL saw_sat got hp0=%0d saw=%0d over=%0d win=%0d", o_hp0, o_saw_armed, o_game_over, o_winner); end
        new_game();
        load(8'h00, 4'd1);
        i_saw = 1; step(); i_saw = 0;
        aim(1'b1); fire();
        total++; if (o_fire_live !== 1'b0 || o_saw_armed !== 1'b0 || o_hp1 !== 3'd4) begin bad++; $display("FAIL saw_blank got=%0d/%0d/%0d exp=0/0/4", o_fire_live, o_saw_armed, o_hp1); end
    endtask
`endif

    initial begin
        test_reset();
        test_live_shot();
        test_blank_self();
        test_last_shell();
        test_game_over();
        test_priority();
        test_clamp();
        test_new_game_prio();
        test_async_reset();
`ifdef DOUBLE_DAMAGE_EN
        test_saw();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
